// File: rtl/semaforo_pkg.sv
// Shared definitions for the traffic-light controller and its pedestrian-button front end.
package semaforo_pkg;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

  // Light phase durations used by semaforo
  localparam logic [7:0] VERDE    = 8'd3;
  localparam logic [7:0] AMARELO  = 8'd1;
  localparam logic [7:0] VERMELHO = 8'd2;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

endpackage

// File: rtl/pedestrian_request_if.sv
// Button / request signals between the pedestrian conditioner and its environment.
interface pedestrian_request_if #(
  parameter int unsigned CNT_W = 8
);
  logic             bt_raw;
  logic             ack;
  logic             bt;
  logic             bt_pulse;
  logic [CNT_W-1:0] press_count;

  modport master (output bt_raw, output ack, input bt, input bt_pulse, input press_count);
  modport slave  (input bt_raw, input ack, output bt, output bt_pulse, output press_count);
endinterface

// File: rtl/sync_ff.sv
// N-stage reset-to-0 synchroniser for asynchronous single-bit inputs.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ff <= '0;
    else      ff <= STAGES'({ff, d});
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/pedestrian_request.sv
// Pedestrian button conditioner: synchronise, debounce, pulse per press, latch request until ack.
module pedestrian_request
  import semaforo_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = 8
) (
  input logic                 clk,
  input logic                 rst,
  pedestrian_request_if.slave bus
);
  localparam logic [CNT_W-1:0] D_VAL   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             fire_c;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.bt_raw),
    .q   (s)
  );

  assign cnt_inc = cnt + CNT_W'(1);
  // Accept fires on the D-th consecutive high sample while not already held
  assign fire_c  = s && ((state == IDLE) || (state == PRESS_WAIT)) && (cnt_inc >= D_VAL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.bt          <= 1'b0;
      bus.bt_pulse    <= 1'b0;
      bus.press_count <= '0;
    end else begin
      bus.bt_pulse <= 1'b0;
      if (bus.ack) bus.bt <= 1'b0;

      case (state)
        IDLE, PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (fire_c) begin
            state <= HELD;
            cnt   <= '0;
          end else begin
            state <= PRESS_WAIT;
            cnt   <= cnt_inc;
          end
        end
        HELD: begin
          if (!s) begin
            state <= RELEASE_WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt_inc >= D_VAL) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt   <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      // A fresh accept overrides a simultaneous ack
      if (fire_c) begin
        bus.bt_pulse <= 1'b1;
        bus.bt       <= 1'b1;
        if (bus.press_count != CNT_MAX) bus.press_count <= bus.press_count + CNT_W'(1);
      end
    end
  end
endmodule
